sensor_init_seq: RTL and testbench

Table-driven register-write sequencer for camera-sensor bring-up, placed directly upstream of the I2C master core. On a start pulse it walks a synchronous configuration table, one 24-bit entry per step, and issues one I2C write request per entry. Each request is held until the core reports completion. The table also encodes millisecond-scale delays and an end marker. Status goes to the CSI receiver control logic.

---
 rtl/sensor_init_if.sv | 32 +++
 rtl/sensor_init_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_sensor_init_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_init_if.sv
// ---------------------------------------------------------------------------
// sensor_init_if
// Request/response bundle between the sensor init sequencer and the I2C
// master core.
//   i2c_rqt     : write request, the core starts on its rising edge
//   cmd         : command, 1 = WRITE
//   addr_dev    : 7-bit device address
//   addr_reg_H/L: register address bytes
//   data_wr_H/L : data bytes (only H carries table data)
//   i2c_done    : core completion level
// master = sequencer side, slave = I2C core side.
// ---------------------------------------------------------------------------
interface sensor_init_if;
   logic       i2c_rqt;
   logic       cmd;
   logic [6:0] addr_dev;
   logic [7:0] addr_reg_H;
   logic [7:0] addr_reg_L;
   logic [7:0] data_wr_H;
   logic [7:0] data_wr_L;
   logic       i2c_done;

   modport master (
      output i2c_rqt, cmd, addr_dev, addr_reg_H, addr_reg_L, data_wr_H, data_wr_L,
      input  i2c_done
   );

   modport slave (
      input  i2c_rqt, cmd, addr_dev, addr_reg_H, addr_reg_L, data_wr_H, data_wr_L,
      output i2c_done
   );
endinterface

// File: rtl/sensor_init_seq.sv
// ---------------------------------------------------------------------------
// sensor_init_seq
// Table-driven register-write sequencer for camera sensor bring-up. On a
// start pulse it walks a synchronous configuration table (one 24-bit word
// {reg_addr[15:0], data[7:0]} per entry) and issues one I2C write per entry,
// holding each request until the core signals completion. reg_addr FFFF ends
// the table, FFFE inserts a delay of data*DLY_UNIT cycles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, starts from entry 0 (ignored while busy)
//   tbl_addr    : table read address
//   tbl_data    : table word, valid one cycle after tbl_addr
//   i2c         : master side of the I2C core request bundle
//   busy        : sequence in progress
//   done        : sequence ended (level)
//   error       : timeout or table overrun, valid while done=1
//   entry_idx   : current or last (failing) entry index
// ---------------------------------------------------------------------------
module sensor_init_seq #(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int         TBL_AW   = 8,
   parameter int         DLY_UNIT = 100000,
   parameter int         RQT_HOLD = 4,
   parameter int         TIMEOUT  = 2000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [23:0]       tbl_data,
   sensor_init_if.master     i2c,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [TBL_AW-1:0] entry_idx
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_REQ       = 4'd3;
   localparam logic [3:0] S_WAIT_DONE = 4'd4;
   localparam logic [3:0] S_WAIT_REL  = 4'd5;
   localparam logic [3:0] S_DELAY     = 4'd6;
   localparam logic [3:0] S_NEXT      = 4'd7;
   localparam logic [3:0] S_END       = 4'd8;
   localparam logic [3:0] S_ERR       = 4'd9;
   localparam logic [3:0] S_OVR       = 4'd10;

   localparam logic [15:0] REG_END = 16'hFFFF;
   localparam logic [15:0] REG_DLY = 16'hFFFE;

   // Delay counter must reach the largest encodable delay, 255 units.
   localparam int DLY_W  = $clog2(255 * DLY_UNIT + 1);
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(RQT_HOLD + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RQT_HOLD - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [DLY_W-1:0]  DLY_UNIT_W = DLY_W'(DLY_UNIT);

   logic [3:0]        state_q,   state_d;
   logic [TBL_AW-1:0] idx_q,     idx_d;
   logic              rqt_q,     rqt_d;
   logic [7:0]        reg_h_q,   reg_h_d;
   logic [7:0]        reg_l_q,   reg_l_d;
   logic [7:0]        wdata_q,   wdata_d;
   logic [HOLD_W-1:0] hold_q,    hold_d;
   logic [TO_W-1:0]   to_q,      to_d;
   logic [DLY_W-1:0]  dly_q,     dly_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              err_q,     err_d;
   logic              cdone_s1_q, cdone_s1_d;
   logic              cdone_s2_q, cdone_s2_d;

   logic [15:0] tbl_reg;
   logic [7:0]  tbl_val;
   logic        cdone_rise;

   assign tbl_reg = tbl_data[23:8];
   assign tbl_val = tbl_data[7:0];

   // Registered edge detect: a level already high before WAIT_DONE has both
   // stages set, so it never looks like a fresh completion.
   assign cdone_rise = cdone_s1_q & ~cdone_s2_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rqt_d      = rqt_q;
      reg_h_d    = reg_h_q;
      reg_l_d    = reg_l_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      to_d       = to_q;
      dly_d      = dly_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      cdone_s1_d = i2c.i2c_done;
      cdone_s2_d = cdone_s1_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (tbl_reg == REG_END) begin
               state_d = S_END;
            end else if (tbl_reg == REG_DLY) begin
               if (tbl_val == 8'd0) begin
                  state_d = S_NEXT;
               end else begin
                  dly_d   = DLY_W'(tbl_val) * DLY_UNIT_W;
                  state_d = S_DELAY;
               end
            end else begin
               reg_h_d = tbl_reg[15:8];
               reg_l_d = tbl_reg[7:0];
               wdata_d = tbl_val;
               rqt_d   = 1'b1;
               hold_d  = '0;
               to_d    = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (hold_q == HOLD_LAST) begin
               rqt_d   = 1'b0;
               state_d = S_WAIT_DONE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (cdone_rise) begin
               state_d = S_WAIT_REL;
            end else if (to_q == TO_LAST) begin
               state_d = S_ERR;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_WAIT_REL: begin
            // Core must be back in idle before the next request edge.
            if (!i2c.i2c_done) begin
               state_d = S_NEXT;
            end
         end
         S_DELAY: begin
            if (dly_q == DLY_W'(1)) begin
               state_d = S_NEXT;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         S_NEXT: begin
            if (idx_q == {TBL_AW{1'b1}}) begin
               state_d = S_OVR;
            end else begin
               idx_d   = idx_q + TBL_AW'(1);
               state_d = S_FETCH;
            end
         end
         S_END: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         S_ERR, S_OVR: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         rqt_q      <= 1'b0;
         reg_h_q    <= 8'd0;
         reg_l_q    <= 8'd0;
         wdata_q    <= 8'd0;
         hold_q     <= '0;
         to_q       <= '0;
         dly_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cdone_s1_q <= 1'b0;
         cdone_s2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rqt_q      <= rqt_d;
         reg_h_q    <= reg_h_d;
         reg_l_q    <= reg_l_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         to_q       <= to_d;
         dly_q      <= dly_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cdone_s1_q <= cdone_s1_d;
         cdone_s2_q <= cdone_s2_d;
      end
   end

   assign tbl_addr       = idx_q;
   assign entry_idx      = idx_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = err_q;

   assign i2c.i2c_rqt    = rqt_q;
   assign i2c.cmd        = 1'b1;
   assign i2c.addr_dev   = DEV_ADDR;
   assign i2c.addr_reg_H = reg_h_q;
   assign i2c.addr_reg_L = reg_l_q;
   assign i2c.data_wr_H  = wdata_q;
   assign i2c.data_wr_L  = 8'h00;

endmodule

// File: tb/tb_sensor_init_seq.sv
// ---------------------------------------------------------------------------
// tb_sensor_init_seq
// Scoreboard bench for sensor_init_seq: a table reference model predicts the
// write transactions and final status of each run; a monitor pops and
// compares them as the DUT presents request edges and the end of a sequence.
// An I2C core model answers requests in normal, never-done and stale modes.
// ---------------------------------------------------------------------------
module tb_sensor_init_seq;
   localparam int         TBL_AW   = 2;
   localparam int         DLY_UNIT = 10;
   localparam int         RQT_HOLD = 4;
   localparam int         TIMEOUT  = 100;
   localparam logic [6:0] DEV_ADDR = 7'h3C;

   localparam int CM_NORMAL = 0;
   localparam int CM_NEVER  = 1;
   localparam int CM_STALE  = 2;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [TBL_AW-1:0] tbl_addr;
   logic [23:0]       tbl_data;
   logic              busy;
   logic              done;
   logic              error;
   logic [TBL_AW-1:0] entry_idx;

   sensor_init_if i2c ();

   sensor_init_seq #(
      .DEV_ADDR (DEV_ADDR),
      .TBL_AW   (TBL_AW),
      .DLY_UNIT (DLY_UNIT),
      .RQT_HOLD (RQT_HOLD),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .i2c       (i2c.master),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .entry_idx (entry_idx)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int busy_fall_cyc = 0;
   int n_wr_exp = 0;
   int core_mode = CM_NORMAL;

   logic [23:0]       tbl_mem [4];
   logic [23:0]       exp_wr [$];
   logic [TBL_AW+1:0] exp_st [$];
   int                rise_cyc [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: walk the table as the sequence rules describe and
   // predict every write plus the final {done, error, entry_idx}.
   task automatic model_push();
      logic [15:0] ra;
      n_wr_exp = 0;
      for (int i = 0; i < 4; i++) begin
         ra = tbl_mem[i][23:8];
         if (ra == 16'hFFFF) begin
            exp_st.push_back({1'b1, 1'b0, TBL_AW'(i)});
            return;
         end
         if (ra != 16'hFFFE) begin
            exp_wr.push_back(tbl_mem[i]);
            n_wr_exp++;
            if (core_mode == CM_NEVER) begin
               exp_st.push_back({1'b1, 1'b1, TBL_AW'(i)});
               return;
            end
         end
      end
      exp_st.push_back({1'b1, 1'b1, TBL_AW'(3)});
   endtask

   task automatic load_tbl(input logic [23:0] w0, input logic [23:0] w1,
                           input logic [23:0] w2, input logic [23:0] w3);
      tbl_mem[0] = w0;
      tbl_mem[1] = w1;
      tbl_mem[2] = w2;
      tbl_mem[3] = w3;
   endtask

   task automatic start_pulse();
      @(posedge clk);
      #1 start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_st.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
         exp_wr.delete();
         exp_st.delete();
      end
   endtask

   task automatic run_seq();
      rise_cyc.delete();
      model_push();
      start_pulse();
      wait_idle(4000);
      chk("pulse_count", rise_cyc.size(), n_wr_exp);
   endtask

   function automatic logic [23:0] rand_write();
      logic [15:0] ra;
      ra = 16'($urandom_range(0, 16'hFFEF));
      return {ra, 8'($urandom_range(0, 255))};
   endfunction

   // Table ROM with one cycle of read latency, and the I2C core model.
   initial begin
      int t;
      bit armed;
      logic rq_prev;
      logic [TBL_AW-1:0] addr_prev;
      t = 0;
      armed = 1'b0;
      rq_prev = 1'b0;
      addr_prev = '0;
      tbl_data = 24'd0;
      i2c.i2c_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tbl_data = tbl_mem[addr_prev];
         addr_prev = tbl_addr;
         if (!rst_n) begin
            armed = 1'b0;
            rq_prev = 1'b0;
            i2c.i2c_done = 1'b0;
         end else begin
            if (i2c.i2c_rqt && !rq_prev) begin
               armed = 1'b1;
               t = 0;
            end else if (armed) begin
               t++;
            end
            rq_prev = i2c.i2c_rqt;
            case (core_mode)
               CM_NORMAL: i2c.i2c_done = armed && t >= 50 && t < 70;
               CM_NEVER:  i2c.i2c_done = 1'b0;
               default:   i2c.i2c_done = armed && (t < 10 || (t >= 30 && t < 50));
            endcase
            if (armed && t >= 80) armed = 1'b0;
         end
      end
   end

   // Monitor: compares each request and each sequence end against the queues.
   initial begin
      logic rq_prev;
      logic bz_prev;
      int width;
      logic [23:0] e;
      logic [TBL_AW+1:0] s;
      rq_prev = 1'b0;
      bz_prev = 1'b0;
      width = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rq_prev = 1'b0;
            bz_prev = 1'b0;
            width = 0;
         end else begin
            if (i2c.i2c_rqt) begin
               if (!rq_prev) begin
                  rise_cyc.push_back(cyc);
                  if (exp_wr.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_rqt: got request %h, expected none",
                              {i2c.addr_reg_H, i2c.addr_reg_L, i2c.data_wr_H});
                  end else begin
                     e = exp_wr.pop_front();
                     chk("wr_word", {i2c.addr_reg_H, i2c.addr_reg_L, i2c.data_wr_H}, e);
                     chk("wr_consts", {i2c.cmd, i2c.addr_dev, i2c.data_wr_L},
                         {1'b1, DEV_ADDR, 8'h00});
                  end
               end
               width++;
            end else if (rq_prev) begin
               chk("rqt_width", width, RQT_HOLD);
               width = 0;
            end
            if (bz_prev && !busy) begin
               busy_fall_cyc = cyc;
               if (exp_st.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_end: got end status %h, expected none",
                           {done, error, entry_idx});
               end else begin
                  s = exp_st.pop_front();
                  chk("end_status", {done, error, entry_idx}, s);
               end
            end
            rq_prev = i2c.i2c_rqt;
            bz_prev = busy;
         end
      end
   end

   initial begin
      bit ok;
      rst_n = 1'b0;
      start = 1'b0;
      load_tbl(24'd0, 24'd0, 24'd0, 24'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tbl_addr", tbl_addr, 0);
      chk("rst_rqt", i2c.i2c_rqt, 0);
      chk("rst_regs", {i2c.addr_reg_H, i2c.addr_reg_L, i2c.data_wr_H}, 0);
      chk("rst_status", {busy, done, error, entry_idx}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Two writes then end marker.
      core_mode = CM_NORMAL;
      load_tbl(24'h300882, 24'h310303, 24'hFFFF00, 24'h123456);
      run_seq();
      chk("first_rqt_latency", rise_cyc.size() > 0 ? rise_cyc[0] - start_cyc : -1, 3);

      // Delay entry ahead of a write.
      load_tbl(24'hFFFE03, 24'h010001, 24'hFFFF00, 24'h000000);
      run_seq();
      chk("delay_latency", rise_cyc.size() > 0 ? rise_cyc[0] - start_cyc : -1,
          6 + 3 * DLY_UNIT);

      // Core never completes: timeout.
      core_mode = CM_NEVER;
      load_tbl(rand_write(), 24'hFFFF00, 24'h000000, 24'h000000);
      run_seq();
      chk("timeout_latency", rise_cyc.size() > 0 ? busy_fall_cyc - rise_cyc[0] : -1,
          RQT_HOLD + TIMEOUT + 1);
      core_mode = CM_NORMAL;

      // No end marker: table overrun after four writes.
      load_tbl(rand_write(), rand_write(), rand_write(), rand_write());
      run_seq();

      // start while busy is ignored.
      load_tbl(24'h300882, 24'h310303, 24'hFFFF00, 24'h000000);
      rise_cyc.delete();
      model_push();
      start_pulse();
      repeat (20) @(posedge clk);
      start_pulse();
      wait_idle(4000);
      chk("restart_ignored_count", rise_cyc.size(), n_wr_exp);

      // Reset asserted during a request.
      model_push();
      start_pulse();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i2c.i2c_rqt) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reached_req", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rqt", i2c.i2c_rqt, 0);
      chk("midrst_status", {busy, done, error, tbl_addr}, 0);
      exp_wr.delete();
      exp_st.delete();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_seq();

      // Stale completion level at WAIT_DONE entry.
      core_mode = CM_STALE;
      load_tbl(rand_write(), rand_write(), 24'hFFFF00, 24'h000000);
      run_seq();
      chk("stale_gap_ok", rise_cyc.size() > 1 ? (rise_cyc[1] - rise_cyc[0] >= 50) : 0, 1);
      core_mode = CM_NORMAL;

      // Randomized tables.
      for (int n = 0; n < 6; n++) begin
         for (int j = 0; j < 4; j++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)      tbl_mem[j] = rand_write();
            else if (r < 8) tbl_mem[j] = {16'hFFFE, 8'($urandom_range(0, 2))};
            else            tbl_mem[j] = {16'hFFFF, 8'($urandom_range(0, 255))};
         end
         run_seq();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
